// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential double-dabble binary-to-BCD converter.
// Holds the FSM state encoding, the digit width and a sizing helper.
package bin2bcd_seq_pkg;

    localparam int unsigned NIB = 4;

    // 2'd3 is unused and recovers to StIdle.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Producer/consumer handshake bundle for bin2bcd_seq.
// The master side is the surrounding system; the slave side is the converter.
interface bin2bcd_seq_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);

    logic                                        in_valid;
    logic                                        in_ready;
    logic [WIDTH-1:0]                            bin_in;
    logic                                        out_valid;
    logic                                        out_ready;
    logic [bin2bcd_seq_pkg::NIB*DIGITS-1:0]      bcd_out;
    logic                                        busy;

    modport master (
        output in_valid,
        output bin_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bcd_out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  bin_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bcd_out,
        output busy
    );

endinterface

// File: rtl/nibble_converter.sv
// Double-dabble digit cell: adds 3 to a BCD digit of 5 or more before the shift.
// Carry-out is intentionally dropped; legal digits never overflow.
module nibble_converter (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble shift/adjust step per clock,
// valid/ready handshakes on both sides, registered outputs.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    bin2bcd_seq_if.slave     bus
);

    localparam int unsigned BcdW = NIB * DIGITS;

    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end
    if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_bad_cnt
        $error("bin2bcd_seq: CNT_W too small for WIDTH");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("bin2bcd_seq: WIDTH must be at least 2");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  bin_sr_q, bin_sr_d;
    logic [BcdW-1:0]   bcd_sr_q, bcd_sr_d;
    logic [BcdW-1:0]   bcd_out_q, bcd_out_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [BcdW-1:0]   bcd_adj;
    logic [BcdW-1:0]   bcd_shift;
    logic              unused_adj_msb;

    for (genvar g = 0; g < DIGITS; g++) begin : g_nib
        nibble_converter u_nib (
            .digit_i (bcd_sr_q[g*NIB +: NIB]),
            .digit_o (bcd_adj[g*NIB +: NIB])
        );
    end

    assign bcd_shift      = {bcd_adj[BcdW-2:0], bin_sr_q[WIDTH-1]};
    assign unused_adj_msb = bcd_adj[BcdW-1];

    always_comb begin
        state_d   = state_q;
        bin_sr_d  = bin_sr_q;
        bcd_sr_d  = bcd_sr_q;
        bcd_out_d = bcd_out_q;
        cnt_d     = cnt_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid && in_ready_q) begin
                    bin_sr_d = bus.bin_in;
                    bcd_sr_d = '0;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = StShift;
                end
            end
            StShift: begin
                bin_sr_d = {bin_sr_q[WIDTH-2:0], 1'b0};
                bcd_sr_d = bcd_shift;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Publish the final shifted value together with the DONE transition.
                    bcd_out_d = bcd_shift;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready && out_valid_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
        busy_d      = (state_d == StShift);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bin_sr_q    <= '0;
            bcd_sr_q    <= '0;
            bcd_out_q   <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_sr_q    <= bin_sr_d;
            bcd_sr_q    <= bcd_sr_d;
            bcd_out_q   <= bcd_out_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.bcd_out   = bcd_out_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (WIDTH=8, DIGITS=3).
module tb_bin2bcd_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bin2bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus ();

    bin2bcd_seq #(
        .WIDTH  (8),
        .DIGITS (3),
        .CNT_W  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Called at a negedge while idle; returns at the negedge after the accept edge.
    task automatic accept(input logic [7:0] v);
        bus.in_valid = 1'b1;
        bus.bin_in   = v;
        chk("accept_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("accept_busy", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_result(input string tag, input logic [11:0] exp);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_value"}, 32'(bus.bcd_out), 32'(exp));
    endtask

    task automatic handshake(input string tag, input logic [11:0] exp);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_hs_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_hs_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_hs_hold"}, 32'(bus.bcd_out), 32'(exp));
    endtask

    initial begin
        logic saw_valid;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.bin_in    = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_bcd", 32'(bus.bcd_out), 32'h000);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        accept(8'd255); wait_result("c255", 12'h255); handshake("c255", 12'h255);
        accept(8'd0);   wait_result("c0",   12'h000); handshake("c0",   12'h000);
        accept(8'd99);  wait_result("c99",  12'h099); handshake("c99",  12'h099);
        accept(8'd128); wait_result("c128", 12'h128); handshake("c128", 12'h128);
        accept(8'd10);  wait_result("c10",  12'h010); handshake("c10",  12'h010);

        // Backpressure
        accept(8'd173);
        wait_result("bp", 12'h173);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_value", 32'(bus.bcd_out), 32'h173);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        handshake("bp", 12'h173);

        // Operand presented while busy must wait for IDLE
        accept(8'd42);
        bus.in_valid = 1'b1;
        bus.bin_in   = 8'd200;
        @(negedge clk);
        chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
        chk("busy_still_shift", 32'(bus.busy), 32'd1);
        while (!bus.out_valid && checks < 100000) @(negedge clk);
        chk("busy_value", 32'(bus.bcd_out), 32'h042);
        handshake("busy", 12'h042);
        accept(8'd200); wait_result("c200", 12'h200); handshake("c200", 12'h200);

        // Reset during the 4th SHIFT cycle
        accept(8'd201);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_bcd", 32'(bus.bcd_out), 32'h000);
        saw_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw_valid = saw_valid | bus.out_valid;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            saw_valid = saw_valid | bus.out_valid;
        end
        chk("mid_rst_no_valid", 32'(saw_valid), 32'd0);
        accept(8'd7); wait_result("c7", 12'h007); handshake("c7", 12'h007);

        // Exhaustive sweep with random consumer stalls
        for (int v = 0; v < 256; v++) begin
            accept(8'(v));
            wait_result("sweep", ref_bcd(v));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake("sweep", ref_bcd(v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
